// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-serial RAM arbiter: transfer lengths, FSM/owner
// encodings and the latched transfer descriptor.
package mem_arbiter_pkg;

    localparam logic [1:0] LenByte = 2'b00;
    localparam logic [1:0] LenHalf = 2'b01;
    localparam logic [1:0] LenWord = 2'b10;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbAccess,
        ArbDone
    } arb_state_e;

    typedef enum logic {
        OwnIf,
        OwnMem
    } owner_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    // 2'b11 is an alias for a full word.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LenByte: return 3'd1;
            LenHalf: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the arbiter; slave is the arbiter's view,
// master the view of whatever drives requests and models the RAM.
interface mem_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_done_o;
    logic [31:0] if_inst_o;
    logic        mem_req_i;
    logic        mem_wr_i;
    logic [31:0] mem_addr_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [7:0]  ram_din_i;
    logic [7:0]  ram_dout_o;
    logic [31:0] ram_a_o;
    logic        ram_wr_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  mem_req_i, mem_wr_i, mem_addr_i, mem_len_i, mem_wdata_i,
        input  ram_din_i,
        output if_done_o, if_inst_o, mem_done_o, mem_rdata_o,
        output ram_dout_o, ram_a_o, ram_wr_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output mem_req_i, mem_wr_i, mem_addr_i, mem_len_i, mem_wdata_i,
        output ram_din_i,
        input  if_done_o, if_inst_o, mem_done_o, mem_rdata_o,
        input  ram_dout_o, ram_a_o, ram_wr_o
    );
endinterface

// File: rtl/ram_byte_seq.sv
// Byte sequencer: walks addr..addr+L-1 one byte per cycle, selects write bytes
// and assembles read bytes that return one cycle after their address.
module ram_byte_seq
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  xfer_t       req,
    input  logic [7:0]  din,
    output logic        last,
    output logic        rd_last,
    output logic [31:0] rdata,
    output logic [31:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr
);

    logic        busy_q, wr_q, rd_act_q, cap_q;
    logic [31:0] addr_q, wdata_q, asm_q;
    logic [2:0]  nbytes_q, k_q;
    logic [1:0]  j_q;
    logic        wr_last;
    logic [31:0] next_a;

    // rd_act_q: a read address is on the bus this cycle; cap_q: din holds
    // the byte for last cycle's address and belongs in lane j_q.
    always_comb begin
        rdata                     = asm_q;
        rdata[{j_q, 3'b000} +: 8] = din;
        rd_last = busy_q && !wr_q && cap_q && ({1'b0, j_q} == nbytes_q - 3'd1);
        wr_last = busy_q && wr_q && (k_q == nbytes_q);
        last    = rd_last || wr_last;
        next_a  = addr_q + {29'd0, k_q};
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy_q   <= 1'b0;
            wr_q     <= 1'b0;
            rd_act_q <= 1'b0;
            cap_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            nbytes_q <= '0;
            k_q      <= '0;
            j_q      <= '0;
            ram_a    <= '0;
            ram_dout <= '0;
            ram_wr   <= 1'b0;
        end else if (start) begin
            busy_q   <= 1'b1;
            wr_q     <= req.wr;
            rd_act_q <= !req.wr;
            cap_q    <= 1'b0;
            addr_q   <= req.addr;
            wdata_q  <= req.wdata;
            asm_q    <= '0;
            nbytes_q <= len_bytes(req.len);
            k_q      <= 3'd1;
            j_q      <= '0;
            ram_a    <= req.addr;
            ram_dout <= req.wdata[7:0];
            ram_wr   <= req.wr;
        end else if (busy_q) begin
            if (last) begin
                busy_q   <= 1'b0;
                rd_act_q <= 1'b0;
                cap_q    <= 1'b0;
                ram_a    <= '0;
                ram_dout <= '0;
                ram_wr   <= 1'b0;
            end else begin
                cap_q <= rd_act_q;
                if (cap_q) begin
                    asm_q <= rdata;
                    j_q   <= j_q + 2'd1;
                end
                if (k_q < nbytes_q) begin
                    ram_a    <= next_a;
                    ram_dout <= wdata_q[{k_q[1:0], 3'b000} +: 8];
                    k_q      <= k_q + 3'd1;
                end else begin
                    // reads only: all addresses issued, waiting on the last byte
                    ram_a    <= '0;
                    ram_dout <= '0;
                    rd_act_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between fetch and MEM: MEM-priority grant,
// non-preemptive transfers, fetch flush, and registered done/data routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    xfer_t       req;
    logic        grant_mem, grant_if, start, abort;
    logic        last, rd_last;
    logic        fin_if, fin_mem;
    logic [31:0] rdata;
    logic        if_done_q, mem_done_q;
    logic [31:0] if_inst_q, mem_rdata_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        abort     = 1'b0;
        fin_if    = 1'b0;
        fin_mem   = 1'b0;
        req       = '{wr: bus.mem_wr_i, len: bus.mem_len_i,
                      addr: bus.mem_addr_i, wdata: bus.mem_wdata_i};
        unique case (state_q)
            ArbIdle: begin
                if (bus.mem_req_i) begin
                    grant_mem = 1'b1;
                    owner_d   = OwnMem;
                    state_d   = ArbAccess;
                end else if (bus.if_req_i && !bus.if_flush_i) begin
                    grant_if = 1'b1;
                    owner_d  = OwnIf;
                    state_d  = ArbAccess;
                    req      = '{wr: 1'b0, len: LenWord,
                                 addr: bus.if_addr_i, wdata: '0};
                end
            end
            ArbAccess: begin
                // a flush in the final cycle still wins: the fetch is discarded
                if (owner_q == OwnIf && bus.if_flush_i) begin
                    abort   = 1'b1;
                    state_d = ArbIdle;
                end else if (last) begin
                    state_d = ArbDone;
                    fin_if  = (owner_q == OwnIf);
                    fin_mem = (owner_q == OwnMem);
                end
            end
            ArbDone: state_d = ArbIdle;
            default: state_d = ArbIdle;
        endcase
    end

    assign start = grant_mem || grant_if;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ArbIdle;
            owner_q     <= OwnIf;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            if_done_q  <= fin_if;
            mem_done_q <= fin_mem;
            if (fin_if) if_inst_q <= rdata;
            if (fin_mem && rd_last) mem_rdata_q <= rdata;
        end
    end

    ram_byte_seq u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .req      (req),
        .din      (bus.ram_din_i),
        .last     (last),
        .rd_last  (rd_last),
        .rdata    (rdata),
        .ram_a    (bus.ram_a_o),
        .ram_dout (bus.ram_dout_o),
        .ram_wr   (bus.ram_wr_o)
    );

    assign bus.if_done_o   = if_done_q;
    assign bus.if_inst_o   = if_inst_q;
    assign bus.mem_done_o  = mem_done_q;
    assign bus.mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model plus a word-level reference memory,
// directed scenarios followed by random MEM/IF transactions.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [7:0]  ram     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    bit          ram_ok;
    logic [31:0] last_mem_rd, last_if, got_data;

    function automatic logic [7:0] pat(input int i);
        logic [31:0] t;
        t = i * 37 + 11;
        return t[7:0];
    endfunction

    // RAM: registered read, byte for cycle c's address appears in c+1
    always @(posedge clk) begin
        if (!ram_ok) begin
            for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
            ram_ok <= 1'b1;
        end else if (bus.ram_wr_o) begin
            ram[bus.ram_a_o[9:0]] <= bus.ram_dout_o;
        end
        bus.ram_din_i <= ram[bus.ram_a_o[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int len);
        logic [31:0] w, ab;
        w = '0;
        for (int b = 0; b < len; b++) begin
            ab = a + 32'(b);
            w[8*b +: 8] = ref_mem[ab[9:0]];
        end
        return w;
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ram_a"}, bus.ram_a_o, 0);
        chk({tag, "_ram_wr"}, bus.ram_wr_o, 0);
        chk({tag, "_ram_dout"}, bus.ram_dout_o, 0);
        chk({tag, "_if_done"}, bus.if_done_o, 0);
        chk({tag, "_mem_done"}, bus.mem_done_o, 0);
        chk({tag, "_if_inst"}, bus.if_inst_o, 0);
        chk({tag, "_mem_rdata"}, bus.mem_rdata_o, 0);
    endtask

    // One transaction from an idle arbiter; request raised in cycle T.
    task automatic run_txn(input bit is_if, input bit wr_in, input logic [31:0] addr,
                           input logic [1:0] len, input logic [31:0] wdata);
        logic [31:0] a_log [0:15];
        logic        w_log [0:15];
        logic [7:0]  d_log [0:15];
        logic [31:0] exp_w, ab;
        int          nb, got, stray, exp_cyc;
        bit          wr;
        wr = is_if ? 1'b0 : wr_in;
        nb = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
        got = 0;
        stray = 0;
        got_data = '0;
        @(negedge clk);
        if (is_if) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = addr;
        end else begin
            bus.mem_req_i   = 1'b1;
            bus.mem_wr_i    = wr;
            bus.mem_addr_i  = addr;
            bus.mem_len_i   = len;
            bus.mem_wdata_i = wdata;
        end
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            a_log[i] = bus.ram_a_o;
            w_log[i] = bus.ram_wr_o;
            d_log[i] = bus.ram_dout_o;
            if (is_if ? bus.mem_done_o : bus.if_done_o) stray++;
            if (is_if ? bus.if_done_o : bus.mem_done_o) begin
                got = i;
                got_data = is_if ? bus.if_inst_o : bus.mem_rdata_o;
                bus.if_req_i  = 1'b0;
                bus.mem_req_i = 1'b0;
                break;
            end
        end
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
        exp_cyc = wr ? nb + 1 : nb + 2;
        chk("done_cycle", got, exp_cyc);
        chk("stray_done", stray, 0);
        for (int i = 1; i <= nb; i++) begin
            chk("ram_a", a_log[i], addr + 32'(i - 1));
            chk("ram_wr", {31'd0, w_log[i]}, {31'd0, wr});
            if (wr) chk("ram_dout", d_log[i], wdata[8*(i-1) +: 8]);
        end
        if (got != 0) begin
            chk("ram_a_at_done", a_log[got], 0);
            chk("ram_wr_at_done", w_log[got], 0);
        end
        if (wr) begin
            for (int b = 0; b < nb; b++) begin
                ab = addr + 32'(b);
                ref_mem[ab[9:0]] = wdata[8*b +: 8];
            end
        end else begin
            exp_w = ref_word(addr, nb);
            if (is_if) begin
                chk("if_inst", got_data, exp_w);
                last_if = exp_w;
            end else begin
                chk("mem_rdata", got_data, exp_w);
                last_mem_rd = exp_w;
            end
        end
        if (is_if) chk("mem_rdata_hold", bus.mem_rdata_o, last_mem_rd);
        else       chk("if_inst_hold", bus.if_inst_o, last_if);
    endtask

    initial begin
        int          md, id, stray;
        logic [31:0] a1, a5, mdat, idat, rnd_addr;
        rst = 1'b1;
        bus.if_req_i = 0; bus.if_addr_i = 0; bus.if_flush_i = 0;
        bus.mem_req_i = 0; bus.mem_wr_i = 0; bus.mem_addr_i = 0;
        bus.mem_len_i = 0; bus.mem_wdata_i = 0;
        last_mem_rd = 0; last_if = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // RAM bytes 11,22,33,44 at 0x100, then LW
        run_txn(0, 1, 32'h100, 2'b10, 32'h44332211);
        run_txn(0, 0, 32'h100, 2'b10, 0);
        chk("lw_0x100", got_data, 32'h44332211);

        // SH 0xBEEF to 0x20, read back as half
        run_txn(0, 1, 32'h20, 2'b01, 32'h0000BEEF);
        run_txn(0, 0, 32'h20, 2'b01, 0);
        chk("lh_0x20", got_data, 32'h0000BEEF);

        // simultaneous IF and MEM: MEM LB first, IF right after
        @(negedge clk);
        bus.mem_req_i = 1; bus.mem_wr_i = 0; bus.mem_addr_i = 32'h101; bus.mem_len_i = 2'b00;
        bus.if_req_i = 1; bus.if_addr_i = 32'h200;
        md = 0; id = 0; a1 = 0; a5 = 0; mdat = 0; idat = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) a1 = bus.ram_a_o;
            if (i == 5) a5 = bus.ram_a_o;
            if (bus.mem_done_o) begin md = i; mdat = bus.mem_rdata_o; bus.mem_req_i = 0; end
            if (bus.if_done_o) begin id = i; idat = bus.if_inst_o; bus.if_req_i = 0; end
            if (id != 0) break;
        end
        bus.mem_req_i = 0; bus.if_req_i = 0;
        chk("both_mem_done_cyc", md, 3);
        chk("both_if_done_cyc", id, 10);
        chk("both_first_addr", a1, 32'h101);
        chk("both_if_addr", a5, 32'h200);
        chk("both_mem_data", mdat, ref_word(32'h101, 1));
        chk("both_if_data", idat, ref_word(32'h200, 4));
        last_mem_rd = ref_word(32'h101, 1);
        last_if = ref_word(32'h200, 4);

        // flush in IDLE blocks the grant; flush mid-fetch aborts it
        @(negedge clk);
        bus.if_req_i = 1; bus.if_addr_i = 32'h8; bus.if_flush_i = 1;
        @(negedge clk);
        chk("flush_idle_block", bus.ram_a_o, 0);
        bus.if_flush_i = 0;
        @(negedge clk);
        chk("fetch_addr", bus.ram_a_o, 32'h8);
        @(negedge clk);
        stray = bus.if_done_o ? 1 : 0;
        bus.if_flush_i = 1; bus.if_addr_i = 32'h40;
        @(negedge clk);
        chk("flush_ram_a", bus.ram_a_o, 0);
        chk("flush_no_done", bus.if_done_o, 0);
        bus.if_flush_i = 0;
        id = 0; a1 = 0; idat = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) a1 = bus.ram_a_o;
            if (bus.if_done_o) begin id = i; idat = bus.if_inst_o; break; end
        end
        bus.if_req_i = 0;
        chk("flush_stray", stray, 0);
        chk("refetch_addr", a1, 32'h40);
        chk("refetch_done_cyc", id, 6);
        chk("refetch_data", idat, ref_word(32'h40, 4));
        last_if = ref_word(32'h40, 4);

        // LW across the 2^32 wrap
        run_txn(0, 0, 32'hFFFF_FFFE, 2'b10, 0);

        // reset at T+2 of an SW
        @(negedge clk);
        bus.mem_req_i = 1; bus.mem_wr_i = 1; bus.mem_addr_i = 32'h300;
        bus.mem_len_i = 2'b10; bus.mem_wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("sw_wr_t1", bus.ram_wr_o, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("midrst");
        rst = 1'b0;
        bus.mem_req_i = 0;
        ref_mem[10'h300] = 8'h0D;
        ref_mem[10'h301] = 8'hF0;
        last_mem_rd = 0; last_if = 0;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_done_o || bus.if_done_o) stray++;
        end
        chk("midrst_no_done", stray, 0);
        run_txn(0, 0, 32'h2FE, 2'b10, 0);

        // random mix, back-to-back
        for (int n = 0; n < 40; n++) begin
            rnd_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                   : $urandom;
            run_txn($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), rnd_addr,
                    2'($urandom_range(0, 3)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
